// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Brief    : Parametrised universal shift register with hold / shift-right /
//             shift-left / parallel-load modes and a counted burst engine that
//             shifts a programmed number of bits per start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic             busy,
  output logic             done
);

  // Per-cycle mode encoding
  localparam logic [1:0] C_MODE_HOLD = 2'b00;
  localparam logic [1:0] C_MODE_SHR  = 2'b01;
  localparam logic [1:0] C_MODE_SHL  = 2'b10;
  localparam logic [1:0] C_MODE_LOAD = 2'b11;

  // Register width expressed in the burst-count width, used for clamping
  localparam logic [CW-1:0] C_WIDTH_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] C_ONE_CNT   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_rem;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [CW-1:0]    w_cnt_clamp;

  // Candidate next values for the two shift directions
  assign w_shr = {s_in_r, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], s_in_l};

  // Burst lengths beyond the register width collapse to a full-width burst
  assign w_cnt_clamp = (cnt > C_WIDTH_CNT) ? C_WIDTH_CNT : cnt;

  // Control FSM and datapath: per-cycle modes in IDLE, counted shifts in RUN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
      r_q     <= RST_VAL;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // A burst request takes priority over any per-cycle mode
            r_rem <= w_cnt_clamp;
            r_dir <= dir;
            if (w_cnt_clamp != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (en) begin
            case (mode)
              C_MODE_SHR:  r_q <= w_shr;
              C_MODE_SHL:  r_q <= w_shl;
              C_MODE_LOAD: r_q <= p_in;
              C_MODE_HOLD: r_q <= r_q;
              default:     r_q <= r_q;
            endcase
          end
        end

        S_RUN: begin
          r_q   <= r_dir ? w_shl : w_shr;
          r_rem <= r_rem - C_ONE_CNT;
          if (r_rem == C_ONE_CNT) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          // One-cycle completion pulse; any request seen here is dropped
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are direct taps of registered state
  assign q       = r_q;
  assign s_out_r = r_q[0];
  assign s_out_l = r_q[WIDTH-1];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Brief    : Directed self-checking bench for univ_shift_reg (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             arstn;
  logic             en;
  logic [1:0]       mode;
  logic             s_in_r;
  logic             s_in_l;
  logic [WIDTH-1:0] p_in;
  logic             start;
  logic             dir;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic             s_out_r;
  logic             s_out_l;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;

  univ_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (4'b0000)
  ) u_dut (
    .clk     (clk),
    .arstn   (arstn),
    .en      (en),
    .mode    (mode),
    .s_in_r  (s_in_r),
    .s_in_l  (s_in_l),
    .p_in    (p_in),
    .start   (start),
    .dir     (dir),
    .cnt     (cnt),
    .q       (q),
    .s_out_r (s_out_r),
    .s_out_l (s_out_l),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en     = 1'b0;
    mode   = 2'b00;
    s_in_r = 1'b0;
    s_in_l = 1'b0;
    p_in   = '0;
    start  = 1'b0;
    dir    = 1'b0;
    cnt    = '0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    en   = 1'b1;
    mode = 2'b11;
    p_in = val;
    tick();
    en   = 1'b0;
    mode = 2'b00;
  endtask

  initial begin
    int busy_cycles;
    int budget;
    logic [WIDTH-1:0] siso_exp [4];
    logic             siso_in  [4];

    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    arstn = 1'b0;
    #12;
    arstn = 1'b1;
    tick();

    // ---- 1: async reset with no clock edge ----
    do_load(4'b1111);
    check("pre_reset_load", 32'(q), 32'hF);
    #3;
    arstn = 1'b0;
    #1;
    check("async_rst_q",    32'(q),    32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    #2;
    arstn = 1'b1;
    tick();

    // ---- 2: SISO equivalence via SHR ----
    siso_in  = '{1'b1, 1'b0, 1'b1, 1'b1};
    siso_exp = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    en   = 1'b1;
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      s_in_r = siso_in[i];
      tick();
      check($sformatf("siso_q%0d", i), 32'(q), 32'(siso_exp[i]));
    end
    check("siso_sout_r", 32'(s_out_r), 32'h1);
    // HOLD keeps the value
    mode = 2'b00;
    tick();
    check("hold_q", 32'(q), 32'hD);
    // en=0 ignores mode
    en   = 1'b0;
    mode = 2'b11;
    p_in = 4'b0110;
    tick();
    check("en0_q", 32'(q), 32'hD);
    idle_inputs();

    // ---- 3: load and shift left ----
    do_load(4'b1001);
    check("load_q",      32'(q),       32'h9);
    check("load_sout_l", 32'(s_out_l), 32'h1);
    check("load_sout_r", 32'(s_out_r), 32'h1);
    en     = 1'b1;
    mode   = 2'b10;
    s_in_l = 1'b0;
    tick();
    check("shl1_q", 32'(q), 32'h2);
    tick();
    check("shl2_q", 32'(q), 32'h4);
    check("shl2_sout_l", 32'(s_out_l), 32'h0);
    idle_inputs();

    // ---- 4: burst right, cnt=3 ----
    do_load(4'b1010);
    start  = 1'b1;
    dir    = 1'b0;
    cnt    = 3'd3;
    s_in_r = 1'b0;
    tick();
    start = 1'b0;
    check("b3_e0_q",    32'(q),    32'hA);
    check("b3_e0_busy", 32'(busy), 32'h1);
    tick();
    check("b3_e1_q",    32'(q),    32'h5);
    check("b3_e1_busy", 32'(busy), 32'h1);
    tick();
    check("b3_e2_q",    32'(q),    32'h2);
    check("b3_e2_busy", 32'(busy), 32'h1);
    tick();
    check("b3_e3_q",    32'(q),    32'h1);
    check("b3_e3_busy", 32'(busy), 32'h0);
    check("b3_e3_done", 32'(done), 32'h1);
    tick();
    check("b3_e4_done", 32'(done), 32'h0);
    check("b3_e4_q",    32'(q),    32'h1);
    // back in IDLE: a per-cycle mode works again
    en   = 1'b1;
    mode = 2'b01;
    s_in_r = 1'b1;
    tick();
    check("b3_idle_shr", 32'(q), 32'h8);
    idle_inputs();

    // ---- 5a: cnt=0, with en/LOAD asserted alongside (start wins) ----
    do_load(4'b0110);
    start = 1'b1;
    cnt   = 3'd0;
    en    = 1'b1;
    mode  = 2'b11;
    p_in  = 4'b1111;
    tick();
    idle_inputs();
    check("c0_e0_done", 32'(done), 32'h1);
    check("c0_e0_busy", 32'(busy), 32'h0);
    check("c0_e0_q",    32'(q),    32'h6);
    tick();
    check("c0_e1_done", 32'(done), 32'h0);
    check("c0_e1_busy", 32'(busy), 32'h0);
    check("c0_e1_q",    32'(q),    32'h6);

    // ---- 5b: cnt=7 clamps to 4 shifts ----
    do_load(4'b0000);
    start  = 1'b1;
    dir    = 1'b1;
    cnt    = 3'd7;
    s_in_l = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    budget      = 0;
    while (!done && budget < 20) begin
      if (busy) busy_cycles++;
      tick();
      budget++;
    end
    check("c7_timeout",   32'(budget < 20), 32'h1);
    check("c7_busy_cyc",  32'(busy_cycles), 32'd4);
    check("c7_shifts",    32'(budget),      32'd4);
    check("c7_q",         32'(q),           32'hF);
    idle_inputs();
    tick();

    // ---- 6a: start / en / mode during RUN and DONE are ignored ----
    do_load(4'b0000);
    start  = 1'b1;
    dir    = 1'b1;
    cnt    = 3'd2;
    s_in_l = 1'b1;
    tick();                       // E0
    start = 1'b1;                 // re-request during RUN
    dir   = 1'b0;
    cnt   = 3'd4;
    tick();                       // E1
    check("ab_e1_q", 32'(q), 32'h1);
    start = 1'b0;
    en    = 1'b1;
    mode  = 2'b11;
    p_in  = 4'b1111;
    tick();                       // E2 ends the two-bit burst
    check("ab_e2_q",    32'(q),    32'h3);
    check("ab_e2_done", 32'(done), 32'h1);
    check("ab_e2_busy", 32'(busy), 32'h0);
    en    = 1'b0;
    start = 1'b1;                 // dropped in DONE
    cnt   = 3'd3;
    tick();                       // E3
    start = 1'b0;
    check("ab_e3_busy", 32'(busy), 32'h0);
    check("ab_e3_done", 32'(done), 32'h0);
    tick();
    check("ab_e4_busy", 32'(busy), 32'h0);
    check("ab_e4_q",    32'(q),    32'h3);
    idle_inputs();

    // ---- 6b: reset mid-burst aborts without done ----
    do_load(4'b1111);
    start = 1'b1;
    dir   = 1'b0;
    cnt   = 3'd4;
    tick();
    start = 1'b0;
    tick();
    check("rb_mid_busy", 32'(busy), 32'h1);
    #3;
    arstn = 1'b0;
    #1;
    check("rb_rst_q",    32'(q),    32'h0);
    check("rb_rst_busy", 32'(busy), 32'h0);
    check("rb_rst_done", 32'(done), 32'h0);
    #2;
    arstn = 1'b1;
    budget = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) budget++;
    end
    check("rb_no_done", 32'(budget), 32'd0);
    check("rb_post_q",  32'(q),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
